// File: rtl/array_ram_fadd_32bkb.sv
// array_ram_fadd_32bkb: pipelined binary32 adder (OP=0) or multiplier (OP=1), RNE rounding, flush-to-zero
module array_ram_fadd_32bkb #(
  parameter int OP = 0,
  parameter int LATENCY = (OP == 0) ? 4 : 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [31:0] din0,
  input  logic [31:0] din1,
  output logic [31:0] dout
);
  localparam logic [31:0] QNAN = 32'h7fc00000;
  function automatic logic [31:0] pack(input logic s, input int e, input logic [22:0] f);
    return e >= 255 ? {s, 8'hff, 23'd0} : e <= 0 ? {s, 31'd0} : {s, e[7:0], f};
  endfunction
  function automatic logic [31:0] round_pack(input logic s, input int e, input logic [23:0] m, input logic g, input logic st);
    logic [24:0] r;
    r = {1'b0, m} + 25'(g & (st | m[0]));
    return pack(s, r[24] ? e + 1 : e, r[24] ? r[23:1] : r[22:0]);
  endfunction
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [27:0] mx, my, s;
    logic [26:0] n;
    logic za, zb, ia, ib;
    int d, e, lz;
    za = a[30:23] == 8'd0;
    zb = b[30:23] == 8'd0;
    ia = &a[30:23];
    ib = &b[30:23];
    if ((ia && a[22:0] != 0) || (ib && b[22:0] != 0) || (ia && ib && a[31] != b[31])) return QNAN;
    if (ia) return {a[31], 8'hff, 23'd0};
    if (ib) return {b[31], 8'hff, 23'd0};
    if (za && zb) return {a[31] & b[31], 31'd0};
    if (za) return b;
    if (zb) return a;
    {x, y} = a[30:0] >= b[30:0] ? {a, b} : {b, a};
    d = int'(x[30:23]) - int'(y[30:23]);
    e = int'(x[30:23]);
    mx = {2'b01, x[22:0], 3'd0};
    my = {2'b01, y[22:0], 3'd0};
    // bits shifted past the sticky position collapse into it
    my = d > 26 ? 28'd1 : (my >> d) | 28'(|(my & ((28'd1 << d) - 28'd1)));
    s = x[31] == y[31] ? mx + my : mx - my;
    if (s == 0) return 32'd0;
    lz = 0;
    for (int i = 0; i < 27; i++) if (s[i]) lz = 26 - i;
    if (s[27]) begin
      n = s[27:1] | 27'(s[0]);
      e = e + 1;
    end else begin
      n = s[26:0] << lz;
      e = e - lz;
    end
    return round_pack(x[31], e, n[26:3], n[2], |n[1:0]);
  endfunction
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic s, za, zb, ia, ib;
    int e;
    s = a[31] ^ b[31];
    za = a[30:23] == 8'd0;
    zb = b[30:23] == 8'd0;
    ia = &a[30:23];
    ib = &b[30:23];
    if ((ia && a[22:0] != 0) || (ib && b[22:0] != 0) || (ia && zb) || (ib && za)) return QNAN;
    if (ia || ib) return {s, 8'hff, 23'd0};
    if (za || zb) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    return p[47] ? round_pack(s, e + 1, p[47:24], p[23], |p[22:0])
                 : round_pack(s, e, p[46:23], p[22], |p[21:0]);
  endfunction
  logic [31:0] a, b;
  logic [31:0] pipe [LATENCY];
  always_ff @(posedge clk)
    if (reset) begin
      a <= '0;
      b <= '0;
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else if (ce) begin
      a <= din0;
      b <= din1;
      pipe[0] <= OP == 0 ? fadd(a, b) : fmul(a, b);
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  assign dout = pipe[LATENCY-1];
endmodule

module array_RAM_fadd_32bkb (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [31:0] din0,
  input  logic [31:0] din1,
  output logic [31:0] dout
);
  array_ram_fadd_32bkb #(.OP(0)) u (.*);
endmodule

module array_RAM_fmul_32cud (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [31:0] din0,
  input  logic [31:0] din1,
  output logic [31:0] dout
);
  array_ram_fadd_32bkb #(.OP(1)) u (.*);
endmodule

// File: tb/tb_array_ram_fadd_32bkb.sv
// tb_array_ram_fadd_32bkb: directed and random checks of the fadd/fmul pipelines against a real-arithmetic model
module tb_array_ram_fadd_32bkb;
  localparam int LA = 4, LM = 3;
  typedef struct { logic [31:0] v; int rem; } op_t;
  logic clk = 0, reset = 1, ce = 0;
  logic [31:0] din0 = 0, din1 = 0, dadd, dmul, dwrap;
  logic [31:0] ea = 0, em = 0;
  op_t qa[$], qm[$];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  array_ram_fadd_32bkb dut_add (.clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1), .dout(dadd));
  array_RAM_fmul_32cud dut_mul (.clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1), .dout(dmul));
  array_RAM_fadd_32bkb dut_wrap (.clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1), .dout(dwrap));
  function automatic real to_real(input logic [31:0] f);
    if (f[30:23] == 8'hff) return $bitstoreal(f[22:0] != 0 ? 64'h7ff8000000000000 : {f[31], 11'h7ff, 52'd0});
    if (f[30:23] == 8'h00) return $bitstoreal({f[31], 63'd0});
    return $bitstoreal({f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0});
  endfunction
  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] x;
    logic [24:0] k;
    logic [28:0] rest;
    int e;
    x = $realtobits(r);
    if (&x[62:52] && |x[51:0]) return 32'h7fc00000;
    if (&x[62:52]) return {x[63], 8'hff, 23'd0};
    if (x[62:52] == 0) return {x[63], 31'd0};
    e = int'(x[62:52]) - 896;
    rest = x[28:0];
    k = {2'b01, x[51:29]} + 25'(rest > 29'h10000000 || (rest == 29'h10000000 && x[29]));
    if (k[24]) e++;
    if (e >= 255) return {x[63], 8'hff, 23'd0};
    if (e <= 0) return {x[63], 31'd0};
    return {x[63], e[7:0], k[24] ? k[23:1] : k[22:0]};
  endfunction
  function automatic logic [31:0] mdl_add(input logic [31:0] a, input logic [31:0] b);
    return to_f32(to_real(a) + to_real(b));
  endfunction
  function automatic logic [31:0] mdl_mul(input logic [31:0] a, input logic [31:0] b);
    return to_f32(to_real(a) * to_real(b));
  endfunction
  function automatic logic [31:0] rnd();
    logic [31:0] sp [10] = '{32'h0, 32'h80000000, 32'h7f800000, 32'hff800000, 32'h7fc00000,
                             32'h7f7fffff, 32'h00800000, 32'h00000001, 32'h3f800000, 32'hbf800000};
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 4))
      0: return sp[$urandom_range(0, 9)];
      1: return {r[31], 8'($urandom_range(1, 40)), r[22:0]};
      2: return {r[31], 8'($urandom_range(215, 254)), r[22:0]};
      3: return {r[31], 8'($urandom_range(120, 134)), r[22:0]};
      default: return r;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
  endtask
  task automatic step(input logic r, input logic c, input logic [31:0] a, input logic [31:0] b);
    op_t t;
    reset = r;
    ce = c;
    din0 = a;
    din1 = b;
    @(posedge clk);
    if (r) begin
      qa.delete();
      qm.delete();
      ea = 0;
      em = 0;
    end else if (c) begin
      foreach (qa[i]) qa[i].rem--;
      foreach (qm[i]) qm[i].rem--;
      if (qa.size() > 0 && qa[0].rem == 0) begin t = qa.pop_front(); ea = t.v; end
      if (qm.size() > 0 && qm[0].rem == 0) begin t = qm.pop_front(); em = t.v; end
      t.v = mdl_add(a, b); t.rem = LA; qa.push_back(t);
      t.v = mdl_mul(a, b); t.rem = LM; qm.push_back(t);
    end
    #1;
    chk("add_pipe", dadd, ea);
    chk("mul_pipe", dmul, em);
    chk("wrap_add", dwrap, ea);
  endtask
  initial begin
    logic [31:0] a, b;
    chk("model_add", mdl_add(32'h40c00000, 32'h40e00000), 32'h41500000);
    chk("model_mul", mdl_mul(32'h40c00000, 32'h40e00000), 32'h42280000);
    chk("model_cancel", mdl_add(32'h3f800000, 32'hbf800000), 32'h00000000);
    chk("model_negzero", mdl_add(32'h80000000, 32'h80000000), 32'h80000000);
    chk("model_infzero", mdl_mul(32'h7f800000, 32'h00000000), 32'h7fc00000);
    repeat (3) step(1, 1, $urandom, $urandom);
    chk("reset_add", dadd, 32'h0);
    chk("reset_mul", dmul, 32'h0);
    step(0, 1, 32'h40c00000, 32'h40e00000);
    repeat (3) step(0, 1, 0, 0);
    chk("mul_6x7", dmul, 32'h42280000);
    step(0, 1, 0, 0);
    chk("add_6p7", dadd, 32'h41500000);
    step(0, 1, 32'h00000000, 32'h40c00000);
    step(0, 1, 32'h3f800000, 32'hbf800000);
    step(0, 1, 32'h7f800000, 32'hff800000);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0); chk("add_seq_6", dadd, 32'h40c00000);
    step(0, 1, 0, 0); chk("add_seq_cancel", dadd, 32'h00000000);
    step(0, 1, 0, 0); chk("add_seq_infinf", dadd, 32'h7fc00000);
    step(0, 1, 32'h7f7fffff, 32'h40000000);
    step(0, 1, 32'h7f800000, 32'h00000000);
    step(0, 1, 32'h00000001, 32'h3f800000);
    step(0, 1, 0, 0); chk("mul_ovf", dmul, 32'h7f800000);
    step(0, 1, 0, 0); chk("mul_infzero", dmul, 32'h7fc00000);
    step(0, 1, 0, 0); chk("mul_subnorm", dmul, 32'h00000000);
    repeat (5) step(0, 1, 0, 0);
    step(0, 1, 32'h40c00000, 32'h40e00000);
    step(0, 1, 0, 0);
    repeat (3) begin
      step(0, 0, $urandom, $urandom);
      chk("ce_hold_add", dadd, 32'h0);
      chk("ce_hold_mul", dmul, 32'h0);
    end
    step(0, 1, 0, 0);
    step(0, 1, 0, 0); chk("ce_resume_mul", dmul, 32'h42280000);
    step(0, 1, 0, 0); chk("ce_resume_add", dadd, 32'h41500000);
    repeat (5) step(0, 1, 0, 0);
    step(0, 1, 32'h40c00000, 32'h40e00000);
    step(1, 1, 0, 0);
    repeat (6) begin
      step(0, 1, 0, 0);
      chk("rst_cancel_add", dadd, 32'h0);
      chk("rst_cancel_mul", dmul, 32'h0);
    end
    for (int i = 0; i < 3000; i++) begin
      a = rnd();
      b = $urandom_range(0, 7) == 0 ? a ^ 32'h80000000 : rnd();
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, a, b);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
